// File: rtl/pll_lock_rst_seq.sv
// pll_lock_rst_seq: PLL lock synchroniser, lock filter and staged per-channel reset release
module pll_lock_rst_seq #(
    parameter int NUM_CH             = 2,
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_FILTER_CYCLES = 256,
    parameter int RELEASE_GAP        = 16
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [NUM_CH-1:0] PLL_LOCK,
    input  logic              FORCE_RESET,
    input  logic              LOCK_LOST_CLR,
    output logic [NUM_CH-1:0] CH_RESETN,
    output logic              ALL_READY,
    output logic [NUM_CH-1:0] LOCK_LOST,
    output logic [1:0]        STATE
);
    localparam int FW = $clog2(LOCK_FILTER_CYCLES);
    localparam int GW = $clog2(RELEASE_GAP + 1);
    localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {WAIT_LOCK, FILTER, RELEASE, RUN} state_t;

    state_t            state, state_n;
    logic [NUM_CH-1:0] sync [SYNC_STAGES];
    logic [NUM_CH-1:0] lk, chr_n, lost_n;
    logic [FW-1:0]     fcnt, fcnt_n;
    logic [GW-1:0]     gcnt, gcnt_n;
    logic [IW-1:0]     idx, idx_n;
    logic              rdy_n, all_lk;

    assign lk     = sync[SYNC_STAGES-1];
    assign all_lk = &lk;
    assign STATE  = state;

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
            state     <= WAIT_LOCK;
            fcnt      <= '0;
            gcnt      <= '0;
            idx       <= '0;
            CH_RESETN <= '0;
            ALL_READY <= 1'b0;
            LOCK_LOST <= '0;
        end else begin
            sync[0] <= PLL_LOCK;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            state     <= state_n;
            fcnt      <= fcnt_n;
            gcnt      <= gcnt_n;
            idx       <= idx_n;
            CH_RESETN <= chr_n;
            ALL_READY <= rdy_n;
            LOCK_LOST <= lost_n;
        end
    end

    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        gcnt_n  = gcnt;
        idx_n   = idx;
        chr_n   = CH_RESETN;
        rdy_n   = ALL_READY;
        lost_n  = LOCK_LOST_CLR ? '0 : LOCK_LOST;
        case (state)
            WAIT_LOCK: begin
                chr_n = '0;
                rdy_n = 1'b0;
                if (all_lk) begin
                    state_n = FILTER;
                    fcnt_n  = '0;
                end
            end
            FILTER: begin
                fcnt_n = fcnt + 1'b1;
                if (!all_lk) begin
                    state_n = WAIT_LOCK;
                    fcnt_n  = '0;
                end else if (fcnt == FW'(LOCK_FILTER_CYCLES - 1)) begin
                    state_n = RELEASE;
                    fcnt_n  = '0;
                    gcnt_n  = '0;
                    idx_n   = '0;
                end
            end
            RELEASE: begin
                gcnt_n = gcnt + 1'b1;
                if (gcnt == GW'(RELEASE_GAP - 1)) begin
                    chr_n[idx] = 1'b1;
                    gcnt_n     = '0;
                    idx_n      = idx + 1'b1;
                    if (idx == IW'(NUM_CH - 1)) begin
                        state_n = RUN;
                        rdy_n   = 1'b1;
                        idx_n   = '0;
                    end
                end
            end
            default: ;
        endcase
        // Losing lock after the filter has passed is the only case recorded as sticky
        if ((state == RELEASE || state == RUN) && !all_lk) begin
            lost_n  = lost_n | ~lk;
            state_n = WAIT_LOCK;
            chr_n   = '0;
            rdy_n   = 1'b0;
            fcnt_n  = '0;
            gcnt_n  = '0;
            idx_n   = '0;
        end
        if (FORCE_RESET) begin
            lost_n  = LOCK_LOST_CLR ? '0 : LOCK_LOST;
            state_n = WAIT_LOCK;
            chr_n   = '0;
            rdy_n   = 1'b0;
            fcnt_n  = '0;
            gcnt_n  = '0;
            idx_n   = '0;
        end
    end
endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// tb_pll_lock_rst_seq: table-driven check of lock filtering, staged release, loss and force paths
module tb_pll_lock_rst_seq;
    logic       clk = 1'b0;
    logic       rstn_a, frc_a, clr_a;
    logic [1:0] lock_a, chr_a, lost_a, st_a;
    logic       rdy_a;
    logic       rstn_b;
    logic [3:0] lock_b, chr_b, lost_b;
    logic [1:0] st_b;
    logic       rdy_b;
    logic       zero = 1'b0;
    int         tests = 0;
    int         errs = 0;

    always #5 clk = ~clk;

    pll_lock_rst_seq dut_a (
        .CLK(clk), .RESETN(rstn_a), .PLL_LOCK(lock_a), .FORCE_RESET(frc_a),
        .LOCK_LOST_CLR(clr_a), .CH_RESETN(chr_a), .ALL_READY(rdy_a),
        .LOCK_LOST(lost_a), .STATE(st_a)
    );

    pll_lock_rst_seq #(.NUM_CH(4), .SYNC_STAGES(2), .LOCK_FILTER_CYCLES(2), .RELEASE_GAP(1)) dut_b (
        .CLK(clk), .RESETN(rstn_b), .PLL_LOCK(lock_b), .FORCE_RESET(zero),
        .LOCK_LOST_CLR(zero), .CH_RESETN(chr_b), .ALL_READY(rdy_b),
        .LOCK_LOST(lost_b), .STATE(st_b)
    );

    typedef struct {
        logic       rstn;
        logic [1:0] lock;
        logic       frc;
        logic       clr;
        int         n;
        logic [1:0] chr;
        logic       rdy;
        logic [1:0] lost;
        logic [1:0] st;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic rs, input logic [1:0] lk, input logic f, input logic c, input int n,
                       input logic [1:0] ch, input logic r, input logic [1:0] lo, input logic [1:0] s);
        vt.push_back('{rs, lk, f, c, n, ch, r, lo, s});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int id, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, id, got, exp);
        end
    endtask

    logic [3:0] b_chr [5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};

    initial begin
        rstn_a = 0; lock_a = 2'b11; frc_a = 0; clr_a = 0;
        rstn_b = 0; lock_b = 4'b1111;
        // four channels, gap 1, filter 2: consecutive-edge release
        step(2);
        check("b_rst_chr", 0, 8'(chr_b), 8'h0);
        check("b_rst_st", 0, 8'(st_b), 8'h0);
        rstn_b = 1;
        step(2);
        check("b_st_sync", 0, 8'(st_b), 8'h0);
        step(1);
        check("b_st_filter", 0, 8'(st_b), 8'h1);
        step(1);
        check("b_st_filter", 1, 8'(st_b), 8'h1);
        for (int k = 0; k < 5; k++) begin
            step(1);
            check("b_chr", k, 8'(chr_b), 8'(b_chr[k]));
            check("b_rdy", k, 8'(rdy_b), 8'(k == 4));
            check("b_st", k, 8'(st_b), k == 4 ? 8'h3 : 8'h2);
        end
        lock_b = 4'b1011;
        step(2);
        check("b_loss_pre", 0, 8'(chr_b), 8'hf);
        step(1);
        check("b_loss_chr", 0, 8'(chr_b), 8'h0);
        check("b_loss_lost", 0, 8'(lost_b), 8'h4);
        check("b_loss_st", 0, 8'(st_b), 8'h0);
        lock_b = 4'b1111;
        rstn_b = 0;
        step(1);
        check("b_reset_lost", 0, 8'(lost_b), 8'h0);
        check("b_reset_rdy", 0, 8'(rdy_b), 8'h0);

        // defaults: power-up sequence
        add(0, 2'b11, 0, 0,   2, 2'b00, 0, 2'b00, 2'd0);
        add(1, 2'b11, 0, 0,   1, 2'b00, 0, 2'b00, 2'd0);
        add(1, 2'b11, 0, 0,   1, 2'b00, 0, 2'b00, 2'd0);
        add(1, 2'b11, 0, 0,   1, 2'b00, 0, 2'b00, 2'd1);
        add(1, 2'b11, 0, 0, 255, 2'b00, 0, 2'b00, 2'd1);
        add(1, 2'b11, 0, 0,   1, 2'b00, 0, 2'b00, 2'd2);
        add(1, 2'b11, 0, 0,  15, 2'b00, 0, 2'b00, 2'd2);
        add(1, 2'b11, 0, 0,   1, 2'b01, 0, 2'b00, 2'd2);
        add(1, 2'b11, 0, 0,  15, 2'b01, 0, 2'b00, 2'd2);
        add(1, 2'b11, 0, 0,   1, 2'b11, 1, 2'b00, 2'd3);
        // ch0 lock loss in RUN, then relock
        add(1, 2'b10, 0, 0,   2, 2'b11, 1, 2'b00, 2'd3);
        add(1, 2'b10, 0, 0,   1, 2'b00, 0, 2'b01, 2'd0);
        add(1, 2'b11, 0, 0, 290, 2'b01, 0, 2'b01, 2'd2);
        add(1, 2'b11, 0, 0,   1, 2'b11, 1, 2'b01, 2'd3);
        // FORCE_RESET from RUN and in RELEASE after ch0
        add(1, 2'b11, 1, 0,   1, 2'b00, 0, 2'b01, 2'd0);
        add(1, 2'b11, 0, 0,   1, 2'b00, 0, 2'b01, 2'd1);
        add(1, 2'b11, 0, 0, 256, 2'b00, 0, 2'b01, 2'd2);
        add(1, 2'b11, 0, 0,  16, 2'b01, 0, 2'b01, 2'd2);
        add(1, 2'b11, 1, 0,   1, 2'b00, 0, 2'b01, 2'd0);
        add(1, 2'b11, 0, 0,   1, 2'b00, 0, 2'b01, 2'd1);
        add(1, 2'b11, 0, 0, 256, 2'b00, 0, 2'b01, 2'd2);
        add(1, 2'b11, 0, 0,  32, 2'b11, 1, 2'b01, 2'd3);
        // ch1 glitch during FILTER: no sticky set
        add(1, 2'b11, 1, 0,   1, 2'b00, 0, 2'b01, 2'd0);
        add(1, 2'b11, 0, 0,   1, 2'b00, 0, 2'b01, 2'd1);
        add(1, 2'b11, 0, 0,  97, 2'b00, 0, 2'b01, 2'd1);
        add(1, 2'b01, 0, 0,   2, 2'b00, 0, 2'b01, 2'd1);
        add(1, 2'b01, 0, 0,   1, 2'b00, 0, 2'b01, 2'd0);
        add(1, 2'b11, 0, 0,   2, 2'b00, 0, 2'b01, 2'd0);
        add(1, 2'b11, 0, 0,   1, 2'b00, 0, 2'b01, 2'd1);
        add(1, 2'b11, 0, 0, 272, 2'b01, 0, 2'b01, 2'd2);
        add(1, 2'b11, 0, 0,  16, 2'b11, 1, 2'b01, 2'd3);
        // one-cycle reset in RUN clears everything, then full resequence
        add(0, 2'b11, 0, 0,   1, 2'b00, 0, 2'b00, 2'd0);
        add(1, 2'b11, 0, 0,   2, 2'b00, 0, 2'b00, 2'd0);
        add(1, 2'b11, 0, 0,   1, 2'b00, 0, 2'b00, 2'd1);
        add(1, 2'b11, 0, 0, 272, 2'b01, 0, 2'b00, 2'd2);
        add(1, 2'b11, 0, 0,  16, 2'b11, 1, 2'b00, 2'd3);
        // ch1 loss coincident with clear: set wins; then clear alone
        add(1, 2'b01, 0, 0,   2, 2'b11, 1, 2'b00, 2'd3);
        add(1, 2'b01, 0, 1,   1, 2'b00, 0, 2'b10, 2'd0);
        add(1, 2'b11, 0, 0,   1, 2'b00, 0, 2'b10, 2'd0);
        add(1, 2'b11, 0, 1,   1, 2'b00, 0, 2'b00, 2'd0);

        foreach (vt[i]) begin
            rstn_a = vt[i].rstn; lock_a = vt[i].lock; frc_a = vt[i].frc; clr_a = vt[i].clr;
            step(vt[i].n);
            check("chr", i, 8'(chr_a), 8'(vt[i].chr));
            check("rdy", i, 8'(rdy_a), 8'(vt[i].rdy));
            check("lost", i, 8'(lost_a), 8'(vt[i].lost));
            check("state", i, 8'(st_a), 8'(vt[i].st));
        end
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule

// File: doc/pll_lock_rst_seq.md
# pll_lock_rst_seq

Parametrised PLL-lock monitor and staged reset sequencer for up to 4 fabric clock channels. It sits beside the CCC/PLL instances in the processor subsystem. It synchronises each PLL lock output and requires all locks to be stable for a filter window. It then releases the per-channel reset outputs one at a time in index order. Any later loss of lock is captured in a sticky status bit and the full sequence restarts.

## Interface
- NUM_CH, 2, number of monitored PLL lock / reset channels, legal 1..4
- SYNC_STAGES, 2, flops per PLL_LOCK synchroniser, legal 2..4
- LOCK_FILTER_CYCLES, 256, consecutive all-locked cycles required before the release phase, legal 2..65535
- RELEASE_GAP, 16, cycles between successive channel releases (and before the first), legal 1..1023

Ports:
- CLK  input  1  system clock, the only clock
- RESETN  input  1  reset, synchronous and active-low
- PLL_LOCK  input  NUM_CH  PLL lock indicators, asynchronous to CLK
- FORCE_RESET  input  1  synchronous request to reassert all channel resets and restart
- LOCK_LOST_CLR  input  1  synchronous clear of all LOCK_LOST bits
- CH_RESETN  output  NUM_CH  per-channel active-low reset, registered
- ALL_READY  output  1  high when every channel is released, registered
- LOCK_LOST  output  NUM_CH  sticky per-channel loss-of-lock flags, registered
- STATE  output  2  current FSM state: 0 WAIT_LOCK, 1 FILTER, 2 RELEASE, 3 RUN

## Operation
- Each PLL_LOCK bit passes through its own SYNC_STAGES-flop synchroniser; the FSM uses only the synchronised value, called lk below.
- WAIT_LOCK: all CH_RESETN = 0 and ALL_READY = 0. When all lk bits are 1, go to FILTER and clear the filter counter.
- FILTER: the counter increments every cycle.
  - If any lk bit is 0, go to WAIT_LOCK. LOCK_LOST is not set in this state.
  - When the counter equals LOCK_FILTER_CYCLES-1 and all lk bits are 1, go to RELEASE with idx = 0 and gap counter = 0.
- RELEASE: the gap counter increments every cycle.
  - When gap = RELEASE_GAP-1, set CH_RESETN[idx] to 1, increment idx and clear the gap counter.
  - Releasing channel NUM_CH-1 moves the FSM to RUN and sets ALL_READY to 1 in the same edge.
- RUN: CH_RESETN stays all 1s and ALL_READY stays 1 until a lock loss or FORCE_RESET.
- Lock loss in RELEASE or RUN (any lk bit = 0):
  - LOCK_LOST[ch] is set for every ch whose lk bit is 0.
  - All CH_RESETN and ALL_READY are driven to 0.
  - The FSM goes to WAIT_LOCK, and the counters and idx clear.
- FORCE_RESET = 1 in any state:
  - All CH_RESETN and ALL_READY are driven to 0, the FSM goes to WAIT_LOCK, and the counters clear.
  - LOCK_LOST is unchanged.
  - FORCE_RESET takes priority over every FSM transition.
- LOCK_LOST_CLR = 1 clears all LOCK_LOST bits. If a set and a clear occur in the same cycle, the set wins for the affected bit.
- Released channels stay released during RELEASE: CH_RESETN[k] for k < idx remains 1.
- Counters: the filter counter is ceil(log2(LOCK_FILTER_CYCLES)) bits and the gap counter is ceil(log2(RELEASE_GAP+1)) bits. Neither counter wraps, because both are cleared on every state exit.

## Timing
- Reset: while RESETN is sampled low at an edge, the following hold from that edge:
  - STATE = 0 and CH_RESETN = 0.
  - ALL_READY = 0 and LOCK_LOST = 0.
  - All synchroniser flops, counters and idx = 0.
- RESETN asserted in the middle of any state forces these values at the next edge.
- All outputs are registered; no input-to-output combinational paths exist.
- Let E be the first edge at which synchroniser stage 1 samples the final PLL_LOCK bit high:
  - lk is all 1s after edge E+SYNC_STAGES-1.
  - The FSM enters FILTER at E+SYNC_STAGES.
  - It enters RELEASE at E+SYNC_STAGES+LOCK_FILTER_CYCLES.
  - CH_RESETN[k] rises at E+SYNC_STAGES+LOCK_FILTER_CYCLES+(k+1)*RELEASE_GAP.
  - ALL_READY rises together with CH_RESETN[NUM_CH-1].
- Lock-loss latency: with PLL_LOCK low first sampled at edge L, CH_RESETN, ALL_READY and LOCK_LOST update at edge L+SYNC_STAGES.
- FORCE_RESET and LOCK_LOST_CLR latency: outputs update at the edge that samples them high, i.e. one cycle.

## Test plan
1. Defaults, both PLL_LOCK rise together at edge E -> CH_RESETN[0] rises at E+274, CH_RESETN[1] and ALL_READY rise at E+290, LOCK_LOST = 0, STATE = 3.
2. PLL_LOCK[1] glitches low for 3 cycles at E+100 (during FILTER) -> STATE returns to 0, no LOCK_LOST set, and the release timing restarts from the new rise.
3. In RUN, PLL_LOCK[0] drops at edge L -> at L+2, CH_RESETN = 0, ALL_READY = 0, LOCK_LOST = 2'b01 and STATE = 0. After relock, the full sequence repeats and LOCK_LOST stays 2'b01.
4. Lock loss on channel 1 with LOCK_LOST_CLR pulsed in the same cycle LOCK_LOST[1] would set -> LOCK_LOST = 2'b10. A later clear pulse alone gives 2'b00.
5. FORCE_RESET pulse during RELEASE, after CH_RESETN[0] is released -> next edge gives CH_RESETN = 0, STATE = 0 and LOCK_LOST unchanged. Resequencing starts with locks held high.
6. RESETN low for one cycle in RUN, then NUM_CH = 4 with RELEASE_GAP = 1 and LOCK_FILTER_CYCLES = 2 -> all outputs are reset at that edge, and channels 0..3 release on four consecutive edges.
